// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS framing constants, FSM encodings and small helpers
// used by the sync aligner and its statistics block.
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         TS_IDX_W     = 8;

  localparam logic [1:0] SEARCH = 2'b00;
  localparam logic [1:0] VERIFY = 2'b01;
  localparam logic [1:0] LOCKED = 2'b10;

  localparam int TS_STAT_W = 16;

  typedef struct packed {
    logic sop;
    logic eop;
    logic sync_err;
  } ts_flags_t;

  // Byte position within a packet, wrapping after the last byte.
  function automatic logic [TS_IDX_W-1:0] ts_idx_next(input logic [TS_IDX_W-1:0] idx);
    return (idx == TS_IDX_W'(TS_PKT_LEN - 1)) ? '0 : idx + TS_IDX_W'(1);
  endfunction

endpackage

// File: rtl/ts_sync_stats.sv
// Saturating packet and lock-loss counters for the TS sync aligner.
// Only instantiated when TS_SYNC_STATS_EN is defined.
module ts_sync_stats
  import ts_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_done_i,
  input  logic                 lock_lost_i,
  output logic [TS_STAT_W-1:0] pkt_count_o,
  output logic [TS_STAT_W-1:0] lock_loss_count_o
);

  logic [1:0]                 inc;
  logic [TS_STAT_W-1:0]       count_q [2];
  logic [TS_STAT_W-1:0]       count_d [2];

  assign inc = {lock_lost_i, pkt_done_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        count_d[gi] = count_q[gi];
        if (inc[gi] && (count_q[gi] != '1)) begin
          count_d[gi] = count_q[gi] + TS_STAT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_q[gi] <= '0;
        end else begin
          count_q[gi] <= count_d[gi];
        end
      end
    end
  endgenerate

  assign pkt_count_o       = count_q[0];
  assign lock_loss_count_o = count_q[1];

endmodule

// File: rtl/ts_sync_aligner.sv
// MPEG-2 TS sync-byte hunter: SEARCH -> VERIFY -> LOCKED, forwards locked packets
// with sop/eop/sync_err. Define TS_SYNC_STATS_EN to add pkt/lock-loss counters.
module ts_sync_aligner
  import ts_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sop,
  output logic                  eop,
  output logic                  sync_err,
  output logic                  locked
`ifdef TS_SYNC_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [15:0]           lock_loss_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] SYNC     = DATA_WIDTH'(TS_SYNC_BYTE);
  localparam logic [TS_IDX_W-1:0]   IDX_LAST = TS_IDX_W'(TS_PKT_LEN - 1);
  localparam logic [3:0]            LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]            UNLOCK_N = 4'(UNLOCK_COUNT);

  logic [1:0]            state_q, state_d;
  logic [TS_IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]            match_q, match_d;
  logic [3:0]            miss_q, miss_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  ts_flags_t             flags_q;

  logic                  fwd;
  ts_flags_t             flags;
  logic                  is_sync;
  logic                  at_zero;

  assign is_sync = (data_in == SYNC);
  assign at_zero = (idx_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    match_d = match_q;
    miss_d  = miss_q;
    fwd     = 1'b0;
    flags   = '0;
    if (valid_in) begin
      case (state_q)
        SEARCH: begin
          if (is_sync) begin
            state_d = VERIFY;
            idx_d   = TS_IDX_W'(1);
            match_d = 4'd1;
          end
        end
        VERIFY: begin
          idx_d = ts_idx_next(idx_q);
          if (at_zero) begin
            if (is_sync) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 == LOCK_N) begin
                state_d   = LOCKED;
                miss_d    = 4'd0;
                fwd       = 1'b1;
                flags.sop = 1'b1;
              end
            end else begin
              state_d = SEARCH;
            end
          end
        end
        LOCKED: begin
          idx_d     = ts_idx_next(idx_q);
          fwd       = 1'b1;
          flags.sop = at_zero;
          flags.eop = (idx_q == IDX_LAST);
          if (at_zero) begin
            if (is_sync) begin
              miss_d = 4'd0;
            end else begin
              miss_d         = miss_q + 4'd1;
              flags.sync_err = 1'b1;
              // The final tolerated miss drops lock and is itself discarded.
              if (miss_q + 4'd1 == UNLOCK_N) begin
                state_d = SEARCH;
                fwd     = 1'b0;
              end
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      idx_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      valid_q <= fwd;
      flags_q <= fwd ? flags : '0;
      if (fwd) begin
        data_q <= data_in;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sop       = flags_q.sop;
  assign eop       = flags_q.eop;
  assign sync_err  = flags_q.sync_err;
  assign locked    = (state_q == LOCKED);

`ifdef TS_SYNC_STATS_EN
  logic pkt_done;
  logic lock_lost;

  assign pkt_done  = fwd && flags.eop;
  assign lock_lost = (state_q == LOCKED) && (state_d == SEARCH);

  ts_sync_stats u_stats (
    .clk               (clk),
    .rst_n             (rst_n),
    .pkt_done_i        (pkt_done),
    .lock_lost_i       (lock_lost),
    .pkt_count_o       (pkt_count),
    .lock_loss_count_o (lock_loss_count)
  );
`endif

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Self-checking bench for ts_sync_aligner: per-cycle reference model, scenario
// table and hand-written corner sequences (reset, false sync, clean lock).
module tb_ts_sync_aligner;

  localparam int LOCK   = 3;
  localparam int UNLOCK = 3;
  localparam int PKT    = 188;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, sop, eop, sync_err, locked;
`ifdef TS_SYNC_STATS_EN
  logic [15:0] pkt_count, lock_loss_count;
`endif

  always #5 clk = ~clk;

  ts_sync_aligner #(.DATA_WIDTH(8), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sop       (sop),
    .eop       (eop),
    .sync_err  (sync_err),
    .locked    (locked)
`ifdef TS_SYNC_STATS_EN
    ,
    .pkt_count       (pkt_count),
    .lock_loss_count (lock_loss_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position counted from the hunted sync, plain integers.
  int m_mode, m_pos, m_hits, m_misses, m_pkts, m_losses;
  // Observations of the DUT during the current sequence.
  int o_bytes, o_sops, o_eops, o_errs, o_vouts, o_first;

  typedef struct {
    int        offset;
    int        n_pkts;
    int        gap;
    bit [15:0] bad;
    int        e_sops;
    int        e_errs;
    bit        e_locked;
    int        e_losses;
  } scen_t;

  scen_t scen [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = M_SEARCH; m_pos = 0; m_hits = 0; m_misses = 0; m_pkts = 0; m_losses = 0;
  endtask

  task automatic obs_reset();
    o_bytes = 0; o_sops = 0; o_eops = 0; o_errs = 0; o_vouts = 0; o_first = -1;
  endtask

  task automatic model_step(input logic [7:0] b, output bit f, output bit s,
                            output bit e, output bit r);
    int pos_in_pkt;
    f = 0; s = 0; e = 0; r = 0;
    pos_in_pkt = m_pos % PKT;
    if (m_mode == M_SEARCH) begin
      if (b == 8'h47) begin
        m_mode = M_VERIFY; m_pos = 1; m_hits = 1;
      end
    end else if (m_mode == M_VERIFY) begin
      if (pos_in_pkt == 0) begin
        if (b == 8'h47) begin
          m_hits++;
          if (m_hits >= LOCK) begin
            m_mode = M_LOCKED; m_misses = 0; f = 1; s = 1;
          end
        end else begin
          m_mode = M_SEARCH;
        end
      end
      m_pos++;
    end else begin
      f = 1;
      s = (pos_in_pkt == 0);
      e = (pos_in_pkt == PKT - 1);
      if (pos_in_pkt == 0) begin
        if (b == 8'h47) m_misses = 0;
        else begin
          m_misses++;
          r = 1;
          if (m_misses >= UNLOCK) begin
            m_mode = M_SEARCH; f = 0; m_losses++;
          end
        end
      end
      if (f && e) m_pkts++;
      m_pos++;
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] b);
    bit f, s, e, r;
    @(negedge clk);
    valid_in = v;
    data_in  = b;
    f = 0; s = 0; e = 0; r = 0;
    if (v) begin
      model_step(b, f, s, e, r);
      o_bytes++;
    end
    @(posedge clk);
    #1;
    check("cycle", {19'h0, valid_out, locked, (valid_out ? {data_out, sop, eop, sync_err} : 11'h0)},
                   {19'h0, f, (m_mode == M_LOCKED), (f ? {b, s, e, r} : 11'h0)});
    if (valid_out) o_vouts++;
    if (valid_out && sop) begin
      o_sops++;
      if (o_first < 0) o_first = o_bytes - 1;
    end
    if (valid_out && eop) o_eops++;
    if (valid_out && sync_err) o_errs++;
  endtask

  function automatic logic [7:0] body_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 254));
    if (b >= 8'h47) b = b + 8'd1;
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    while ($urandom_range(0, 99) < gap) drive(1'b0, 8'($urandom));
    drive(1'b1, b);
  endtask

  task automatic send_pkt(input logic [7:0] first, input int gap);
    send_byte(first, gap);
    for (int i = 1; i < PKT; i++) send_byte(body_byte(), gap);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {18'h0, data_out, valid_out, sop, eop, sync_err, locked}, 32'h0);
`ifdef TS_SYNC_STATS_EN
    check({name, "_stats"}, {pkt_count, lock_loss_count}, 32'h0);
`endif
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = 8'h00;
    rst_n    = 1'b0;
    #1;
    check_reset_outs("reset_outs");
    repeat (2) @(negedge clk);
    model_reset();
    obs_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    scen[0] = '{0,  4, 0,  16'h0000, 2, 0, 1'b1, 0};
    scen[1] = '{17, 5, 0,  16'h0008, 3, 1, 1'b1, 0};
    scen[2] = '{0,  7, 0,  16'h0038, 3, 2, 1'b0, 1};
    scen[3] = '{3,  5, 50, 16'h0000, 3, 0, 1'b1, 0};
    scen[4] = '{0,  6, 30, 16'h0028, 4, 2, 1'b1, 0};
    scen[5] = '{0,  5, 0,  16'h0002, 1, 0, 1'b1, 0};

    model_reset();
    obs_reset();
    #2;

    // Clean lock: first sop on the third packet's sync, eop on its last byte.
    do_reset();
    for (int k = 0; k < 3; k++) send_pkt(8'h47, 0);
    check("clean_first_sop", o_first, 2 * PKT);
    check("clean_eops", o_eops, 1);
    check("clean_locked", {31'h0, locked}, 1);

    // False sync: lone 0x47, no sync 188 bytes later, then real alignment.
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(body_byte(), 0);
    send_byte(8'h47, 0);
    for (int i = 0; i < PKT; i++) send_byte(body_byte(), 0);
    check("false_no_vout", o_vouts, 0);
    check("false_unlocked", {31'h0, locked}, 0);
    for (int k = 0; k < 3; k++) send_pkt(8'h47, 0);
    check("false_relock_sops", o_sops, 1);
    check("false_relocked", {31'h0, locked}, 1);

    // Table of multi-packet scenarios with misses, offsets and gaps.
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int i = 0; i < scen[s].offset; i++) send_byte(body_byte(), scen[s].gap);
      for (int k = 0; k < scen[s].n_pkts; k++)
        send_pkt(scen[s].bad[k] ? 8'h00 : 8'h47, scen[s].gap);
      drive(1'b0, 8'h00);
      check($sformatf("scen%0d_sops", s), o_sops, scen[s].e_sops);
      check($sformatf("scen%0d_errs", s), o_errs, scen[s].e_errs);
      check($sformatf("scen%0d_locked", s), {31'h0, locked}, {31'h0, scen[s].e_locked});
`ifdef TS_SYNC_STATS_EN
      check($sformatf("scen%0d_losses", s), {16'h0, lock_loss_count}, scen[s].e_losses);
      check($sformatf("scen%0d_pkts", s), {16'h0, pkt_count}, m_pkts);
`endif
    end

    // Reset asserted at byte 100 of a locked packet.
    do_reset();
    for (int k = 0; k < 3; k++) send_pkt(8'h47, 0);
    send_byte(8'h47, 0);
    for (int i = 1; i < 100; i++) send_byte(body_byte(), 0);
    check("pre_reset_locked", {31'h0, locked}, 1);
    do_reset();
    #1;
    check_reset_outs("post_release");
    for (int k = 0; k < 3; k++) send_pkt(8'h47, 0);
    check("relock_first_sop", o_first, 2 * PKT);
    check("relock_locked", {31'h0, locked}, 1);
`ifdef TS_SYNC_STATS_EN
    check("relock_pkts", {16'h0, pkt_count}, 1);
`endif

    // Random stream: mostly-correct syncs, bodies may contain 0x47.
    do_reset();
    for (int i = 0; i < 12 * PKT; i++) begin
      logic [7:0] b;
      if ((i % PKT) == 0 && $urandom_range(0, 99) < 80) b = 8'h47;
      else b = 8'($urandom_range(0, 255));
      send_byte(b, 20);
    end
`ifdef TS_SYNC_STATS_EN
    check("rand_pkts", {16'h0, pkt_count}, m_pkts);
    check("rand_losses", {16'h0, lock_loss_count}, m_losses);
`endif
    check("rand_locked", {31'h0, locked}, {31'h0, (m_mode == M_LOCKED)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
